// File: rtl/core_ls_lsu_split_align_if.sv
// Issue-side request, data-memory beat port and completion signals of the LSU alignment stage.
// slave is the alignment stage; master is the issue/memory side driving it.
interface core_ls_lsu_split_align_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  localparam int BYTES = XLEN / 8;

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [XLEN-1:0]  req_wdata;

  logic             mem_valid;
  logic             mem_ready;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [BYTES-1:0] mem_wmask;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;

  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_rdata;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wmask, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/core_ls_lsu_split_align.sv
// LSU alignment stage: splits word-crossing accesses into two aligned beats,
// lane-aligns store data/masks and merges/extends load data.
module core_ls_lsu_split_align #(
  parameter int XLEN           = 32,
  parameter int AW             = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  core_ls_lsu_split_align_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int EW    = OFFW + 4;
  localparam int MW    = 2 * BYTES;
  localparam int DW    = 2 * XLEN;

  typedef enum logic [2:0] {IDLE, B0, W0, B1, W1, RSP} state_t;

  state_t           state_reg;
  logic [OFFW-1:0]  off_reg;
  logic [1:0]       size_reg;
  logic             we_reg;
  logic             uns_reg;
  logic             cross_reg;
  logic [BYTES-1:0] wmask_hi_reg;
  logic [XLEN-1:0]  wdata_hi_reg;
  logic [XLEN-1:0]  lo_reg;

  logic [OFFW-1:0]  req_off;
  logic [EW-1:0]    req_end;
  logic             req_cross;
  logic             req_err;
  logic [MW-1:0]    req_mask2;
  logic [DW-1:0]    req_data2;
  logic [AW-1:0]    beat1_addr;

  // Mask and data are built as a double word: low half is beat 0, high half is beat 1.
  assign req_off    = bus.req_addr[OFFW-1:0];
  assign req_end    = EW'(req_off) + (EW'(1) << bus.req_size);
  assign req_cross  = req_end > EW'(BYTES);
  assign req_err    = ((XLEN < 64) && (bus.req_size == 2'd3)) ||
                      ((ALLOW_MISALIGN == 0) && req_cross);
  assign req_mask2  = ((MW'(1) << (4'd1 << bus.req_size)) - MW'(1)) << req_off;
  assign req_data2  = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
  assign beat1_addr = bus.mem_addr + AW'(BYTES);

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] hi,
                                            input logic [XLEN-1:0] lo,
                                            input logic [OFFW-1:0] off,
                                            input logic [1:0]      size,
                                            input logic            uns);
    logic [DW-1:0]   tmp;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] keep;
    logic            sign;
    int              nbits;
    tmp   = {hi, lo} >> {off, 3'b000};
    val   = tmp[XLEN-1:0];
    nbits = 8 << size;
    if (nbits >= XLEN) return val;
    keep  = (XLEN'(1) << nbits) - XLEN'(1);
    sign  = |(val & ((XLEN'(1) << nbits) >> 1));
    if (!uns && sign) return val | ~keep;
    return val & keep;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      off_reg       <= '0;
      size_reg      <= '0;
      we_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      cross_reg     <= 1'b0;
      wmask_hi_reg  <= '0;
      wdata_hi_reg  <= '0;
      lo_reg        <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wmask <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            off_reg       <= req_off;
            size_reg      <= bus.req_size;
            we_reg        <= bus.req_we;
            uns_reg       <= bus.req_unsigned;
            cross_reg     <= req_cross;
            wmask_hi_reg  <= bus.req_we ? req_mask2[MW-1:BYTES] : '0;
            wdata_hi_reg  <= bus.req_we ? req_data2[DW-1:XLEN] : '0;
            bus.req_ready <= 1'b0;
            if (req_err) begin
              state_reg     <= RSP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state_reg     <= B0;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[AW-1:OFFW], {OFFW{1'b0}}};
              bus.mem_we    <= bus.req_we;
              bus.mem_wmask <= bus.req_we ? req_mask2[BYTES-1:0] : '0;
              bus.mem_wdata <= bus.req_we ? req_data2[XLEN-1:0] : '0;
            end
          end
        end
        B0: begin
          if (bus.mem_ready) begin
            if (!we_reg) begin
              state_reg     <= W0;
              bus.mem_valid <= 1'b0;
            end else if (cross_reg) begin
              state_reg     <= B1;
              bus.mem_addr  <= beat1_addr;
              bus.mem_wmask <= wmask_hi_reg;
              bus.mem_wdata <= wdata_hi_reg;
            end else begin
              state_reg     <= RSP;
              bus.mem_valid <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= '0;
            end
          end
        end
        W0: begin
          if (bus.mem_rvalid) begin
            lo_reg <= bus.mem_rdata;
            if (cross_reg) begin
              state_reg     <= B1;
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= beat1_addr;
              bus.mem_wmask <= '0;
              bus.mem_wdata <= '0;
            end else begin
              state_reg     <= RSP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= merge('0, bus.mem_rdata, off_reg, size_reg, uns_reg);
            end
          end
        end
        B1: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            if (we_reg) begin
              state_reg     <= RSP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state_reg <= W1;
            end
          end
        end
        W1: begin
          if (bus.mem_rvalid) begin
            state_reg     <= RSP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= merge(bus.mem_rdata, lo_reg, off_reg, size_reg, uns_reg);
          end
        end
        RSP: begin
          state_reg     <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        default: begin
          state_reg     <= IDLE;
          bus.req_ready <= 1'b1;
          bus.mem_valid <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_ls_lsu_split_align.sv
// Directed scoreboard bench: instance A is XLEN=32 with splitting, instance B is XLEN=64 trapping.
module tb_core_ls_lsu_split_align;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_ls_lsu_split_align_if #(.XLEN(32), .AW(32)) ifa ();
  core_ls_lsu_split_align_if #(.XLEN(64), .AW(32)) ifb ();

  core_ls_lsu_split_align #(.XLEN(32), .AW(32), .ALLOW_MISALIGN(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  core_ls_lsu_split_align #(.XLEN(64), .AW(32), .ALLOW_MISALIGN(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;
  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  beat_t       beat_a[$], beat_b[$];
  rsp_t        rsp_a[$], rsp_b[$];
  logic [31:0] rd_a[$];
  logic [63:0] rd_b[$];
  int          tests = 0;
  int          fails = 0;
  int          pend_a = 0, pend_b = 0;
  logic        stray_a = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input bit which, input logic [63:0] addr, input logic we,
                           input logic [7:0] mask, input logic [63:0] data);
    beat_t b;
    b.addr = addr; b.we = we; b.mask = mask; b.data = data;
    if (which) beat_b.push_back(b); else beat_a.push_back(b);
  endtask

  task automatic push_rsp(input bit which, input logic [63:0] rdata, input logic err);
    rsp_t r;
    r.rdata = rdata; r.err = err;
    if (which) rsp_b.push_back(r); else rsp_a.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue_a(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    int n = 0;
    while (!ifa.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("a_req_ready", 64'(ifa.req_ready), 64'd1);
    ifa.req_valid = 1'b1; ifa.req_addr = addr; ifa.req_we = we;
    ifa.req_size = size; ifa.req_unsigned = uns; ifa.req_wdata = wdata;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata);
    int n = 0;
    while (!ifb.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("b_req_ready", 64'(ifb.req_ready), 64'd1);
    ifb.req_valid = 1'b1; ifb.req_addr = addr; ifb.req_we = we;
    ifb.req_size = size; ifb.req_unsigned = uns; ifb.req_wdata = wdata;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((beat_a.size() + rsp_a.size() + beat_b.size() + rsp_b.size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 64'(beat_a.size() + rsp_a.size() + beat_b.size() + rsp_b.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory model: answers each accepted read beat one cycle after acceptance.
  initial begin
    ifa.mem_rvalid = 1'b0; ifa.mem_rdata = '0;
    ifb.mem_rvalid = 1'b0; ifb.mem_rdata = '0;
    forever begin
      @(negedge clk);
      ifa.mem_rvalid = 1'b0;
      ifb.mem_rvalid = 1'b0;
      if (rst) begin
        pend_a = 0; pend_b = 0;
      end else begin
        if (stray_a) begin
          ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'h5555AAAA; stray_a = 1'b0;
        end else if (pend_a > 0 && rd_a.size() > 0) begin
          ifa.mem_rvalid = 1'b1; ifa.mem_rdata = rd_a.pop_front(); pend_a--;
        end
        if (pend_b > 0 && rd_b.size() > 0) begin
          ifb.mem_rvalid = 1'b1; ifb.mem_rdata = rd_b.pop_front(); pend_b--;
        end
        if (ifa.mem_valid && ifa.mem_ready && !ifa.mem_we) pend_a++;
        if (ifb.mem_valid && ifb.mem_ready && !ifb.mem_we) pend_b++;
      end
    end
  end

  // Scoreboard monitors: beats are compared every cycle they are valid, popped on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.mem_valid) begin
        if (beat_a.size() == 0) check("a_spurious_beat", 64'(ifa.mem_valid), 64'd0);
        else begin
          check("a_mem_addr", 64'(ifa.mem_addr), beat_a[0].addr);
          check("a_mem_we", 64'(ifa.mem_we), 64'(beat_a[0].we));
          check("a_mem_wmask", 64'(ifa.mem_wmask), 64'(beat_a[0].mask));
          if (beat_a[0].we) check("a_mem_wdata", 64'(ifa.mem_wdata), beat_a[0].data);
          if (ifa.mem_ready) void'(beat_a.pop_front());
        end
      end
      if (ifa.rsp_valid) begin
        $display("[TB] A rsp rdata=%h err=%b", ifa.rsp_rdata, ifa.rsp_err);
        if (rsp_a.size() == 0) check("a_spurious_rsp", 64'(ifa.rsp_valid), 64'd0);
        else begin
          check("a_rsp_rdata", 64'(ifa.rsp_rdata), rsp_a[0].rdata);
          check("a_rsp_err", 64'(ifa.rsp_err), 64'(rsp_a[0].err));
          void'(rsp_a.pop_front());
        end
      end
      if (ifb.mem_valid) begin
        if (beat_b.size() == 0) check("b_spurious_beat", 64'(ifb.mem_valid), 64'd0);
        else begin
          check("b_mem_addr", 64'(ifb.mem_addr), beat_b[0].addr);
          check("b_mem_we", 64'(ifb.mem_we), 64'(beat_b[0].we));
          check("b_mem_wmask", 64'(ifb.mem_wmask), 64'(beat_b[0].mask));
          if (beat_b[0].we) check("b_mem_wdata", ifb.mem_wdata, beat_b[0].data);
          if (ifb.mem_ready) void'(beat_b.pop_front());
        end
      end
      if (ifb.rsp_valid) begin
        $display("[TB] B rsp rdata=%h err=%b", ifb.rsp_rdata, ifb.rsp_err);
        if (rsp_b.size() == 0) check("b_spurious_rsp", 64'(ifb.rsp_valid), 64'd0);
        else begin
          check("b_rsp_rdata", ifb.rsp_rdata, rsp_b[0].rdata);
          check("b_rsp_err", 64'(ifb.rsp_err), 64'(rsp_b[0].err));
          void'(rsp_b.pop_front());
        end
      end
    end
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_we = 1'b0; ifa.req_size = '0;
    ifa.req_unsigned = 1'b0; ifa.req_wdata = '0; ifa.mem_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_we = 1'b0; ifb.req_size = '0;
    ifb.req_unsigned = 1'b0; ifb.req_wdata = '0; ifb.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_req_ready", 64'(ifa.req_ready), 64'd1);
    check("a_rst_mem_valid", 64'(ifa.mem_valid), 64'd0);
    check("a_rst_mem_we", 64'(ifa.mem_we), 64'd0);
    check("a_rst_mem_wmask", 64'(ifa.mem_wmask), 64'd0);
    check("a_rst_mem_addr", 64'(ifa.mem_addr), 64'd0);
    check("a_rst_mem_wdata", 64'(ifa.mem_wdata), 64'd0);
    check("a_rst_rsp", {ifa.rsp_rdata, 31'd0, ifa.rsp_valid | ifa.rsp_err}, 64'd0);
    check("b_rst_req_ready", 64'(ifb.req_ready), 64'd1);
    check("b_rst_mem_valid", 64'(ifb.mem_valid), 64'd0);
    check("b_rst_mem_wmask", 64'(ifb.mem_wmask), 64'd0);
    rst = 1'b0;

    // SW aligned: single full-word beat
    push_beat(0, 64'h100, 1'b1, 8'h0F, 64'h11223344); push_rsp(0, 64'h0, 1'b0);
    issue_a(32'h100, 1'b1, 2'd2, 1'b0, 32'h11223344); wait_done("a_sw_done");
    // SH crossing a word boundary
    push_beat(0, 64'h100, 1'b1, 8'h08, 64'hEF000000);
    push_beat(0, 64'h104, 1'b1, 8'h01, 64'h000000BE); push_rsp(0, 64'h0, 1'b0);
    issue_a(32'h103, 1'b1, 2'd1, 1'b0, 32'h0000BEEF); wait_done("a_sh_cross_done");
    // LW crossing: two read beats merged
    rd_a.push_back(32'hAABBCCDD); rd_a.push_back(32'h11223344);
    push_beat(0, 64'h100, 1'b0, 8'h00, 64'h0); push_beat(0, 64'h104, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'h3344AABB, 1'b0);
    issue_a(32'h102, 1'b0, 2'd2, 1'b0, 32'h0); wait_done("a_lw_cross_done");
    // LB signed and LBU
    rd_a.push_back(32'h00008000); push_beat(0, 64'h100, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'hFFFFFF80, 1'b0);
    issue_a(32'h101, 1'b0, 2'd0, 1'b0, 32'h0); wait_done("a_lb_done");
    rd_a.push_back(32'h00008000); push_beat(0, 64'h100, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'h00000080, 1'b0);
    issue_a(32'h101, 1'b0, 2'd0, 1'b1, 32'h0); wait_done("a_lbu_done");
    // LH signed, upper half
    rd_a.push_back(32'h80010000); push_beat(0, 64'h100, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'hFFFF8001, 1'b0);
    issue_a(32'h102, 1'b0, 2'd1, 1'b0, 32'h0); wait_done("a_lh_done");
    // LHU crossing
    rd_a.push_back(32'hAB000000); rd_a.push_back(32'h000000CD);
    push_beat(0, 64'h100, 1'b0, 8'h00, 64'h0); push_beat(0, 64'h104, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'h0000CDAB, 1'b0);
    issue_a(32'h103, 1'b0, 2'd1, 1'b1, 32'h0); wait_done("a_lhu_cross_done");
    // Size D is illegal on a 32-bit datapath
    push_rsp(0, 64'h0, 1'b1);
    issue_a(32'h200, 1'b0, 2'd3, 1'b0, 32'h0); wait_done("a_ld_err_done");
    // SB into top lane
    push_beat(0, 64'h104, 1'b1, 8'h08, 64'hA5000000); push_rsp(0, 64'h0, 1'b0);
    issue_a(32'h107, 1'b1, 2'd0, 1'b0, 32'h000000A5); wait_done("a_sb_done");
    // SW crossing the top of the address space wraps to 0
    push_beat(0, 64'hFFFFFFFC, 1'b1, 8'h0C, 64'hF00D0000);
    push_beat(0, 64'h00000000, 1'b1, 8'h03, 64'h0000CAFE); push_rsp(0, 64'h0, 1'b0);
    issue_a(32'hFFFFFFFE, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D); wait_done("a_sw_wrap_done");
    // Beat held stable under back-pressure
    ifa.mem_ready = 1'b0;
    push_beat(0, 64'h300, 1'b1, 8'h0F, 64'hDEADBEEF); push_rsp(0, 64'h0, 1'b0);
    issue_a(32'h300, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    repeat (5) @(posedge clk);
    #1;
    ifa.mem_ready = 1'b1;
    wait_done("a_stall_done");
    // Reset while waiting for read data: no response, stray rvalid ignored
    push_beat(0, 64'h400, 1'b0, 8'h00, 64'h0);
    issue_a(32'h400, 1'b0, 2'd2, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("a_w0_no_rsp", 64'(ifa.rsp_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("a_rst_mid_ready", 64'(ifa.req_ready), 64'd1);
    check("a_rst_mid_mem_valid", 64'(ifa.mem_valid), 64'd0);
    check("a_rst_mid_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
    rst = 1'b0;
    stray_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("a_after_stray_ready", 64'(ifa.req_ready), 64'd1);
    rd_a.push_back(32'h12345678); push_beat(0, 64'h500, 1'b0, 8'h00, 64'h0);
    push_rsp(0, 64'h12345678, 1'b0);
    issue_a(32'h500, 1'b0, 2'd2, 1'b0, 32'h0); wait_done("a_post_rst_lw_done");

    // XLEN=64, misalignment trapped
    push_rsp(1, 64'h0, 1'b1);
    issue_b(32'h0C, 1'b0, 2'd3, 1'b0, 64'h0); wait_done("b_ld_mis_err_done");
    rd_b.push_back(64'h87654321_00000000); push_beat(1, 64'h08, 1'b0, 8'h00, 64'h0);
    push_rsp(1, 64'hFFFFFFFF_87654321, 1'b0);
    issue_b(32'h0C, 1'b0, 2'd2, 1'b0, 64'h0); wait_done("b_lw_done");
    push_beat(1, 64'h08, 1'b1, 8'hF0, 64'h89ABCDEF_00000000); push_rsp(1, 64'h0, 1'b0);
    issue_b(32'h0C, 1'b1, 2'd2, 1'b0, 64'h01234567_89ABCDEF); wait_done("b_sw_done");
    push_beat(1, 64'h10, 1'b1, 8'hFF, 64'h01234567_89ABCDEF); push_rsp(1, 64'h0, 1'b0);
    issue_b(32'h10, 1'b1, 2'd3, 1'b0, 64'h01234567_89ABCDEF); wait_done("b_sd_done");
    push_rsp(1, 64'h0, 1'b1);
    issue_b(32'h0E, 1'b1, 2'd2, 1'b0, 64'h0); wait_done("b_sw_mis_err_done");
    push_beat(1, 64'h08, 1'b1, 8'h80, 64'h5A000000_00000000); push_rsp(1, 64'h0, 1'b0);
    issue_b(32'h0F, 1'b1, 2'd0, 1'b0, 64'h5A); wait_done("b_sb_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
